// File: rtl/lut_interp_activation_pipe.sv
// lut_interp_activation_pipe
//   Pipelined activation unit. A signed input z picks a segment of a
//   runtime-loadable table. The output is linearly interpolated between that
//   segment's two endpoints, or set to the base entry in nearest mode.
//   There are 3 stages with one global enable. A new sample is accepted
//   whenever the output register is empty or is being drained.
//
// Ports
//   clk, rst               rising-edge clock, async active-high reset
//   in_valid/in_ready      input handshake; in_z (signed), in_mode (1 = nearest)
//   out_valid/out_ready    output handshake; out_a (signed result)
//   lut_we/lut_waddr/      table write port, entries 0..2^ADDR_W;
//   lut_wdata              writes to out-of-range indices are dropped
module lut_interp_activation_pipe #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_z,
  input  logic                     in_mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_a,
  input  logic                     lut_we,
  input  logic [ADDR_W:0]          lut_waddr,
  input  logic signed [DATA_W-1:0] lut_wdata
);

  localparam int FRAC_W = DATA_W - ADDR_W;
  localparam int NENT   = (1 << ADDR_W) + 1;
  localparam int PW     = DATA_W + FRAC_W + 2;
  localparam int STAGES = 3;

  logic signed [DATA_W-1:0] tbl_q [NENT];

  logic [STAGES:1]          vld_q;
  logic                     en;

  logic [ADDR_W-1:0]        idx1_q;
  logic [FRAC_W-1:0]        frac1_q;
  logic                     mode1_q;

  logic signed [DATA_W-1:0] base2_q, next2_q;
  logic [FRAC_W-1:0]        frac2_q;
  logic                     mode2_q;

  logic signed [DATA_W-1:0] out_a_q;

  logic [ADDR_W-1:0]        idx_d;
  logic [ADDR_W:0]          nidx_d;
  logic signed [DATA_W:0]   diff_d;
  logic signed [PW-1:0]     prod_d;
  logic signed [DATA_W-1:0] res_d;

  assign en        = !vld_q[STAGES] || out_ready;
  assign in_ready  = en;
  assign out_valid = vld_q[STAGES];
  assign out_a     = out_a_q;

  // Offset-binary index: flipping the MSB maps the most negative z to 0.
  always_comb begin
    idx_d = in_z[DATA_W-1 -: ADDR_W];
    idx_d[ADDR_W-1] = ~idx_d[ADDR_W-1];
  end

  // The upper endpoint index is one bit wider, so idx+1 never wraps.
  assign nidx_d = (ADDR_W+1)'(idx1_q) + (ADDR_W+1)'(1);

  // The weight is 0..(2^FRAC_W-1)/2^FRAC_W. The interpolated value therefore
  // stays between base and next, and truncating to DATA_W is lossless.
  always_comb begin
    diff_d = (DATA_W+1)'(next2_q) - (DATA_W+1)'(base2_q);
    prod_d = PW'(diff_d) * PW'($signed({1'b0, frac2_q}));
    res_d  = mode2_q ? base2_q : base2_q + DATA_W'(prod_d >>> FRAC_W);
  end

  // Writes ignore stalls. A same-edge S2 read sees the pre-write value
  // because both use the old tbl_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NENT; i++) tbl_q[i] <= '0;
    end else if (lut_we && (lut_waddr <= (ADDR_W+1)'(NENT-1))) begin
      tbl_q[lut_waddr] <= lut_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q   <= '0;
      idx1_q  <= '0;
      frac1_q <= '0;
      mode1_q <= 1'b0;
      base2_q <= '0;
      next2_q <= '0;
      frac2_q <= '0;
      mode2_q <= 1'b0;
      out_a_q <= '0;
    end else if (en) begin
      vld_q   <= {vld_q[STAGES-1:1], in_valid};
      idx1_q  <= idx_d;
      frac1_q <= in_z[FRAC_W-1:0];
      mode1_q <= in_mode;
      base2_q <= tbl_q[idx1_q];
      next2_q <= tbl_q[nidx_d];
      frac2_q <= frac1_q;
      mode2_q <= mode1_q;
      if (vld_q[STAGES-1]) out_a_q <= res_d;
    end
  end

endmodule

// File: tb/tb_lut_interp_activation_pipe.sv
module tb_lut_interp_activation_pipe;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_z;
  logic                     in_mode;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_a;
  logic                     lut_we;
  logic [ADDR_W:0]          lut_waddr;
  logic signed [DATA_W-1:0] lut_wdata;

  int n_chk  = 0;
  int n_pass = 0;

  lut_interp_activation_pipe #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_z(in_z), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a),
    .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic lut_write(input int addr, input int data);
    @(negedge clk);
    lut_we = 1'b1; lut_waddr = addr[ADDR_W:0]; lut_wdata = data[DATA_W-1:0];
    @(negedge clk);
    lut_we = 1'b0;
  endtask

  // Drive one sample into an idle pipe with out_ready high; check latency and value.
  task automatic run_sample(input string tag, input logic [7:0] z, input logic m, input int exp);
    int lat;
    @(negedge clk);
    in_valid = 1'b1; in_z = z; in_mode = m;
    lat = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      lat++;
    end while (!out_valid && lat < 10);
    chk({tag, "_lat"}, lat, 3);
    chk({tag, "_a"}, int'(out_a), exp);
  endtask

  logic [7:0] bp_z [4] = '{8'h08, 8'h18, 8'h28, 8'h38};
  int         bp_exp [4] = '{8, 24, 40, 56};

  initial begin
    int sent, got, cyc, stall_seen, prev_a, ov_cnt;
    int rx [$];
    logic prev_stall;

    rst = 1'b1; in_valid = 1'b0; in_z = '0; in_mode = 1'b0; out_ready = 1'b1;
    lut_we = 1'b0; lut_waddr = '0; lut_wdata = '0;
    #12;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_a", int'(out_a), 0);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", int'(in_ready), 1);

    // 1: basic interpolation and nearest
    lut_write(9, 10);
    lut_write(10, 30);
    run_sample("t1_interp", 8'h18, 1'b0, 20);
    run_sample("t1_near", 8'h18, 1'b1, 10);

    // 2: most negative segment
    lut_write(0, -100);
    lut_write(1, -60);
    run_sample("t2_z80", 8'h80, 1'b0, -100);
    run_sample("t2_z84", 8'h84, 1'b0, -90);

    // 3: floor rounding, upper endpoint, out-of-range write
    lut_write(9, 0);
    lut_write(10, -1);
    run_sample("t3_floor", 8'h11, 1'b0, -1);
    lut_write(15, 100);
    lut_write(16, 127);
    run_sample("t3_top", 8'h7F, 1'b0, 125);
    lut_write(17, -50);
    run_sample("t3_oor", 8'h7F, 1'b0, 125);

    // 4: backpressure
    lut_write(8, 0);
    lut_write(9, 16);
    lut_write(10, 32);
    lut_write(11, 48);
    lut_write(12, 64);
    sent = 0; got = 0; stall_seen = 0; prev_stall = 1'b0; prev_a = 0;
    for (cyc = 0; cyc < 16; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 5);
      if (sent < 4) begin in_valid = 1'b1; in_z = bp_z[sent]; in_mode = 1'b0; end
      else in_valid = 1'b0;
      #1;
      if (prev_stall) begin
        chk("t4_stable_a", int'(out_a), prev_a);
        chk("t4_stable_v", int'(out_valid), 1);
      end
      if (out_valid && !out_ready) begin
        if (stall_seen == 0) chk("t4_in_ready_low", int'(in_ready), 0);
        stall_seen++;
      end
      prev_stall = out_valid && !out_ready;
      prev_a     = int'(out_a);
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) rx.push_back(int'(out_a));
    end
    in_valid = 1'b0;
    chk("t4_stall_cycles", (stall_seen > 0) ? 1 : 0, 1);
    chk("t4_count", rx.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("t4_res%0d", i), (i < rx.size()) ? rx[i] : -999, bp_exp[i]);

    // 5: write hazard against a sample sitting in S1
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_z = 8'h10; in_mode = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    lut_we = 1'b1; lut_waddr = 5'd9; lut_wdata = 8'sd50;
    @(negedge clk);
    lut_we = 1'b0;
    @(negedge clk);
    chk("t5_hazard_v", int'(out_valid), 1);
    chk("t5_hazard_old", int'(out_a), 16);
    run_sample("t5_new", 8'h10, 1'b0, 50);

    // 6: async reset with two samples in flight
    @(negedge clk);
    in_valid = 1'b1; in_z = 8'h18;
    @(negedge clk);
    in_z = 8'h28;
    @(negedge clk);
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_v", int'(out_valid), 0);
    chk("t6_rst_a", int'(out_a), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    ov_cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) ov_cnt++;
    end
    chk("t6_no_stale", ov_cnt, 0);
    lut_write(10, 40);
    run_sample("t6_tbl_clr", 8'h18, 1'b0, 20);
    run_sample("t6_tbl_near", 8'h18, 1'b1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
